// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation codes,
// controller state encoding and small decode helpers.
package muldiv_pkg;

   typedef enum logic [2:0] {
      OP_MUL   = 3'd0,
      OP_MULU  = 3'd1,
      OP_DIV   = 3'd2,
      OP_DIVU  = 3'd3,
      OP_MADD  = 3'd4,
      OP_MADDU = 3'd5,
      OP_MSUB  = 3'd6,
      OP_MSUBU = 3'd7
   } op_e;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      PREP = 3'd1,
      RUN  = 3'd2,
      FIX  = 3'd3,
      DONE = 3'd4
   } state_e;

   // Divide ops are 2 and 3.
   function automatic logic op_is_div(input logic [2:0] op);
      return (op[2:1] == 2'b01);
   endfunction

   // Signedness decode. With accumulate disabled, ops 4..7 fall back to a
   // plain multiply whose signedness is selected by op[1] (0 = signed).
   function automatic logic op_is_signed(input logic [2:0] op, input logic mac_en);
      if (!op[2] || mac_en)
         return ~op[0];
      else
         return ~op[1];
   endfunction

endpackage

// File: rtl/muldiv_core.sv
// Radix-2 iterative datapath: shift-add multiply and restoring divide on
// unsigned magnitudes, one step per cycle, with its own iteration counter.
// After WIDTH steps {hi, lo} holds the product, or {remainder, quotient}.
module muldiv_core
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             step,
   input  logic             is_div,
   input  logic [WIDTH-1:0] opa,
   input  logic [WIDTH-1:0] opb,
   output logic             last,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] dvs;
   logic [WIDTH-1:0] hi_nx;
   logic [WIDTH-1:0] lo_nx;
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   shifted;
   logic             fits;

   assign last = (cnt == CNT_W'(1));

   // One iteration: add-and-shift-right for multiply, shift-left-and-trial-subtract for divide.
   always_comb begin
      sum     = {1'b0, hi} + (lo[0] ? {1'b0, dvs} : '0);
      shifted = {hi, lo[WIDTH-1]};
      fits    = (shifted >= {1'b0, dvs});
      hi_nx   = sum[WIDTH:1];
      lo_nx   = {sum[0], lo[WIDTH-1:1]};
      if (is_div) begin
         // A successful trial subtract always leaves a value below dvs, so
         // the low WIDTH bits of the difference are exact.
         hi_nx = fits ? (shifted[WIDTH-1:0] - dvs) : shifted[WIDTH-1:0];
         lo_nx = {lo[WIDTH-2:0], fits};
      end
   end

   // Shift register and held operand; loaded once per operation.
   always_ff @(posedge clk) begin
      if (load) begin
         hi  <= '0;
         lo  <= opa;
         dvs <= opb;
      end else if (step) begin
         hi  <= hi_nx;
         lo  <= lo_nx;
      end
   end

   // Iteration counter: WIDTH steps, last step flagged when it reads 1.
   always_ff @(posedge clk) begin
      if (!rst)
         cnt <= '0;
      else if (load)
         cnt <= CNT_W'(WIDTH);
      else if (step)
         cnt <= cnt - CNT_W'(1);
   end

endmodule

// File: rtl/muldiv_unit.sv
// Multiply/divide unit: controller FSM, operand sign handling, result fix-up
// and optional multiply-accumulate. Build option MULDIV_MAC_EN enables the
// MADD/MSUB family; without it ops 4..7 run as plain multiplies and acc_i is
// ignored.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic               start,
   input  logic [2:0]         op,
   input  logic [WIDTH-1:0]   src_a,
   input  logic [WIDTH-1:0]   src_b,
   input  logic [2*WIDTH-1:0] acc_i,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] result,
   output logic               div_zero
);

`ifdef MULDIV_MAC_EN
   localparam logic MAC_EN = 1'b1;
`else
   localparam logic MAC_EN = 1'b0;
`endif

   state_e state;
   state_e state_nx;

   op_e              op_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             neg_q;
   logic             neg_r;

`ifdef MULDIV_MAC_EN
   logic signed [2*WIDTH-1:0] acc_q;
`else
   logic acc_unused;
   assign acc_unused = ^acc_i;
`endif

   logic                      is_div;
   logic                      sgn;
   logic                      neg_a;
   logic                      neg_b;
   logic                      div_by_zero;
   logic [WIDTH-1:0]          mag_a;
   logic [WIDTH-1:0]          mag_b;
   logic                      core_last;
   logic [WIDTH-1:0]          core_hi;
   logic [WIDTH-1:0]          core_lo;
   logic signed [2*WIDTH-1:0] prod_s;
   logic [WIDTH-1:0]          quo;
   logic [WIDTH-1:0]          rem;
   logic [2*WIDTH-1:0]        fix_val;

   function automatic logic [2*WIDTH-1:0] neg_wide(input logic neg, input logic [2*WIDTH-1:0] v);
      return neg ? -v : v;
   endfunction

   function automatic logic [WIDTH-1:0] neg_narrow(input logic neg, input logic [WIDTH-1:0] v);
      return neg ? -v : v;
   endfunction

   assign is_div      = op_is_div(op_q);
   assign sgn         = op_is_signed(op_q, MAC_EN);
   assign neg_a       = sgn & a_q[WIDTH-1];
   assign neg_b       = sgn & b_q[WIDTH-1];
   assign mag_a       = neg_narrow(neg_a, a_q);
   assign mag_b       = neg_narrow(neg_b, b_q);
   assign div_by_zero = is_div && (b_q == '0);

   assign busy = (state != IDLE);
   assign done = (state == DONE);

   muldiv_core #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_core (
      .clk    (clk),
      .rst    (rst),
      .load   (state == PREP),
      .step   (state == RUN),
      .is_div (is_div),
      .opa    (mag_a),
      .opb    (mag_b),
      .last   (core_last),
      .hi     (core_hi),
      .lo     (core_lo)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (!rst)
         state <= IDLE;
      else
         state <= state_nx;
   end

   // Next-state logic; flush overrides every transition.
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (start) state_nx = PREP;
         PREP:    state_nx = div_by_zero ? DONE : RUN;
         RUN:     if (core_last) state_nx = FIX;
         FIX:     state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
      if (flush)
         state_nx = IDLE;
   end

   // Operand capture on acceptance, result signs captured during PREP.
   always_ff @(posedge clk) begin
      if (state == IDLE && start && !flush) begin
         op_q  <= op_e'(op);
         a_q   <= src_a;
         b_q   <= src_b;
`ifdef MULDIV_MAC_EN
         acc_q <= acc_i;
`endif
      end
      if (state == PREP) begin
         neg_q <= neg_a ^ neg_b;
         neg_r <= neg_a;
      end
   end

   // Sign correction of product / quotient / remainder and optional accumulate.
   always_comb begin
      prod_s  = neg_wide(neg_q, {core_hi, core_lo});
      quo     = neg_narrow(neg_q, core_lo);
      rem     = neg_narrow(neg_r, core_hi);
      fix_val = prod_s;
      if (is_div)
         fix_val = {rem, quo};
`ifdef MULDIV_MAC_EN
      else if (op_q[2])
         fix_val = op_q[1] ? (acc_q - prod_s) : (acc_q + prod_s);
`endif
   end

   // Result and divide-by-zero flag, written only on the edge that enters DONE.
   always_ff @(posedge clk) begin
      if (!rst) begin
         result   <= '0;
         div_zero <= 1'b0;
      end else begin
         div_zero <= 1'b0;
         if (!flush) begin
            if (state == FIX) begin
               result <= fix_val;
            end else if (state == PREP && div_by_zero) begin
               result   <= {a_q, {WIDTH{1'b1}}};
               div_zero <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (WIDTH=32), with a plain-arithmetic
// reference model. Honours MULDIV_MAC_EN the same way the design does.
module tb_muldiv_unit;

   logic        clk;
   logic        rst;
   logic        flush;
   logic        start;
   logic [2:0]  op;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic [63:0] acc_i;
   logic        busy;
   logic        done;
   logic [63:0] result;
   logic        div_zero;

   int checks = 0;
   int errors = 0;

   muldiv_unit #(.WIDTH(32)) dut (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .start    (start),
      .op       (op),
      .src_a    (src_a),
      .src_b    (src_b),
      .acc_i    (acc_i),
      .busy     (busy),
      .done     (done),
      .result   (result),
      .div_zero (div_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   // Reference model straight from the arithmetic definitions.
   function automatic void model_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                    input logic [63:0] acc, output logic [63:0] res, output logic dz);
      longint sa;
      longint sb;
      logic [63:0] p;
      logic sgn;
      dz = 1'b0;
      if (o == 3'd2 || o == 3'd3) begin
         if (b == 32'd0) begin
            res = {a, 32'hFFFF_FFFF};
            dz  = 1'b1;
         end else if (o == 3'd2) begin
            sa  = longint'($signed(a));
            sb  = longint'($signed(b));
            res = {32'(sa % sb), 32'(sa / sb)};
         end else begin
            res = {a % b, a / b};
         end
      end else begin
         sgn = !o[0];
`ifndef MULDIV_MAC_EN
         if (o[2]) sgn = !o[1];
`endif
         sa  = sgn ? longint'($signed(a)) : longint'({32'd0, a});
         sb  = sgn ? longint'($signed(b)) : longint'({32'd0, b});
         p   = 64'(sa * sb);
         res = p;
`ifdef MULDIV_MAC_EN
         if (o[2]) res = o[1] ? (acc - p) : (acc + p);
`endif
      end
   endfunction

   function automatic int exp_lat(input logic [2:0] o, input logic [31:0] b);
      return ((o == 3'd2 || o == 3'd3) && b == 32'd0) ? 2 : 35;
   endfunction

   // Drive one operation and report what the DUT did; no comparisons here.
   task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] acc, output logic [63:0] res, output logic dz,
                        output int lat, output logic busy_ok);
      logic got;
      @(negedge clk);
      op = o; src_a = a; src_b = b; acc_i = acc; start = 1'b1;
      lat = 0; busy_ok = 1'b1; res = '0; dz = 1'b0; got = 1'b0;
      while (!got && lat < 100) begin
         @(negedge clk);
         start = 1'b0;
         lat++;
         if (!busy) busy_ok = 1'b0;
         if (done) begin
            res = result;
            dz  = div_zero;
            got = 1'b1;
         end
      end
   endtask

   function automatic logic [31:0] rand_operand();
      case ($urandom_range(0, 5))
         0:       return 32'd0;
         1:       return 32'($urandom_range(1, 15));
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h8000_0000;
         default: return $urandom;
      endcase
   endfunction

   task automatic test_reset();
      rst = 1'b0; start = 1'b1; flush = 1'b0; op = 3'd0; src_a = 32'd5; src_b = 32'd6; acc_i = '0;
      repeat (3) @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
      checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL reset_dz got %b want 0", div_zero); end
      checks++; if (result !== 64'd0) begin errors++; $display("FAIL reset_result got %h want 0", result); end
      start = 1'b0;
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_directed();
      logic [63:0] res;
      logic dz;
      logic bok;
      int lat;
      issue(3'd0, 32'hFFFF_FFFF, 32'h0000_0002, 64'd0, res, dz, lat, bok);
      checks++; if (res !== 64'hFFFF_FFFF_FFFF_FFFE) begin errors++; $display("FAIL mul_neg1x2 got %h want FFFFFFFFFFFFFFFE", res); end
      checks++; if (lat !== 35) begin errors++; $display("FAIL mul_latency got %0d want 35", lat); end
      checks++; if (bok !== 1'b1) begin errors++; $display("FAIL mul_busy got low before done want high"); end
      checks++; if (dz !== 1'b0) begin errors++; $display("FAIL mul_dz got %b want 0", dz); end
      issue(3'd2, 32'hFFFF_FFF9, 32'd2, 64'd0, res, dz, lat, bok);
      checks++; if (res !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin errors++; $display("FAIL div_m7_2 got %h want FFFFFFFFFFFFFFFD", res); end
      issue(3'd3, 32'd7, 32'd0, 64'd0, res, dz, lat, bok);
      checks++; if (lat !== 2) begin errors++; $display("FAIL divz_latency got %0d want 2", lat); end
      checks++; if (res !== {32'd7, 32'hFFFF_FFFF}) begin errors++; $display("FAIL divz_result got %h want 00000007FFFFFFFF", res); end
      checks++; if (dz !== 1'b1) begin errors++; $display("FAIL divz_flag got %b want 1", dz); end
      @(negedge clk);
      checks++; if (div_zero !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL divz_pulse got dz=%b done=%b want 0 0", div_zero, done); end
      issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 64'd0, res, dz, lat, bok);
      checks++; if (res !== {32'd0, 32'h8000_0000}) begin errors++; $display("FAIL div_min_m1 got %h want 0000000080000000", res); end
      checks++; if (dz !== 1'b0) begin errors++; $display("FAIL div_min_m1_dz got %b want 0", dz); end
`ifdef MULDIV_MAC_EN
      issue(3'd6, 32'd3, 32'd4, 64'h0000_000A_0000_0000, res, dz, lat, bok);
      checks++; if (res !== 64'h0000_0009_FFFF_FFF4) begin errors++; $display("FAIL msub got %h want 00000009FFFFFFF4", res); end
`else
      issue(3'd4, 32'hFFFF_FFFF, 32'd2, 64'h1234, res, dz, lat, bok);
      checks++; if (res !== 64'hFFFF_FFFF_FFFF_FFFE) begin errors++; $display("FAIL op4_as_mul got %h want FFFFFFFFFFFFFFFE", res); end
      issue(3'd6, 32'hFFFF_FFFF, 32'd2, 64'h1234, res, dz, lat, bok);
      checks++; if (res !== 64'h0000_0001_FFFF_FFFE) begin errors++; $display("FAIL op6_as_mulu got %h want 00000001FFFFFFFE", res); end
`endif
   endtask

   task automatic test_hold();
      logic [63:0] res;
      logic dz;
      logic bok;
      int lat;
      issue(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 64'd0, res, dz, lat, bok);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++; if (result !== res || done !== 1'b0) begin errors++; $display("FAIL hold got %h done=%b want %h done=0", result, done, res); end
      end
   endtask

   task automatic test_random();
      logic [2:0] o;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] acc;
      logic [63:0] res;
      logic [63:0] exp;
      logic dz;
      logic edz;
      logic bok;
      int lat;
      for (int i = 0; i < 48; i++) begin
         o = 3'($urandom_range(0, 7));
         a = rand_operand();
         b = rand_operand();
         acc = {$urandom, $urandom};
         model_op(o, a, b, acc, exp, edz);
         issue(o, a, b, acc, res, dz, lat, bok);
         checks++; if (res !== exp || dz !== edz) begin errors++; $display("FAIL rand op=%0d a=%h b=%h got %h dz=%b want %h dz=%b", o, a, b, res, dz, exp, edz); end
         checks++; if (lat !== exp_lat(o, b) || bok !== 1'b1) begin errors++; $display("FAIL rand_timing op=%0d got lat %0d busy_ok %b want %0d 1", o, lat, bok, exp_lat(o, b)); end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] a[3];
      logic [31:0] b[3];
      logic [2:0] o[3];
      logic [63:0] res;
      logic [63:0] exp;
      logic dz;
      logic edz;
      logic bok;
      int lat;
      o[0] = 3'd0; a[0] = $urandom; b[0] = $urandom;
      o[1] = 3'd2; a[1] = $urandom; b[1] = 32'($urandom_range(1, 1000));
      o[2] = 3'd3; a[2] = $urandom; b[2] = 32'd0;
      for (int i = 0; i < 3; i++) begin
         model_op(o[i], a[i], b[i], 64'd0, exp, edz);
         issue(o[i], a[i], b[i], 64'd0, res, dz, lat, bok);
         checks++; if (res !== exp || dz !== edz || lat !== exp_lat(o[i], b[i])) begin
            errors++; $display("FAIL b2b[%0d] got %h dz=%b lat=%0d want %h dz=%b lat=%0d", i, res, dz, lat, exp, edz, exp_lat(o[i], b[i]));
         end
      end
   endtask

   task automatic test_flush();
      int pts[3] = '{1, 11, 34};
      logic [63:0] res;
      logic [63:0] prev;
      logic [63:0] exp;
      logic dz;
      logic edz;
      logic bok;
      logic seen;
      int lat;
      int cyc;
      for (int k = 0; k < 3; k++) begin
         src_a = $urandom; src_b = $urandom;
         model_op(3'd1, src_a, src_b, 64'd0, prev, edz);
         issue(3'd1, src_a, src_b, 64'd0, res, dz, lat, bok);
         checks++; if (res !== prev) begin errors++; $display("FAIL flush_setup got %h want %h", res, prev); end
         @(negedge clk);
         op = 3'd0; src_a = $urandom; src_b = $urandom; start = 1'b1;
         cyc = 0; seen = 1'b0;
         while (cyc < pts[k]) begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (done) seen = 1'b1;
         end
         flush = 1'b1;
         @(negedge clk);
         flush = 1'b0;
         checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy at %0d got %b want 0", pts[k], busy); end
         checks++; if (seen || done !== 1'b0) begin errors++; $display("FAIL flush_done at %0d got pulse want none", pts[k]); end
         checks++; if (result !== prev) begin errors++; $display("FAIL flush_result at %0d got %h want %h", pts[k], result, prev); end
         src_a = $urandom; src_b = $urandom;
         model_op(3'd0, src_a, src_b, 64'd0, exp, edz);
         issue(3'd0, src_a, src_b, 64'd0, res, dz, lat, bok);
         checks++; if (res !== exp || lat !== 35) begin errors++; $display("FAIL flush_restart got %h lat %0d want %h lat 35", res, lat, exp); end
      end
   endtask

   task automatic test_flush_start();
      logic [63:0] prev;
      logic seen;
      prev = result;
      @(negedge clk);
      op = 3'd1; src_a = 32'd9; src_b = 32'd9; start = 1'b1; flush = 1'b1;
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_start_busy got %b want 0", busy); end
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (done || busy) seen = 1'b1;
      end
      checks++; if (seen || result !== prev) begin errors++; $display("FAIL flush_start_accepted got result %h activity %b want %h 0", result, seen, prev); end
   endtask

   task automatic test_reset_mid();
      logic [63:0] res;
      logic [63:0] exp;
      logic dz;
      logic edz;
      logic bok;
      int lat;
      @(negedge clk);
      op = 3'd3; src_a = 32'd100; src_b = 32'd0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_setup busy got %b want 1", busy); end
      @(negedge clk);
      checks++; if (div_zero !== 1'b1) begin errors++; $display("FAIL mid_setup dz got %b want 1", div_zero); end
      @(negedge clk);
      op = 3'd1; src_a = $urandom; src_b = $urandom; start = 1'b1;
      repeat (10) begin
         @(negedge clk);
         start = 1'b0;
      end
      rst = 1'b0; flush = 1'b1; start = 1'b1;
      @(negedge clk);
      rst = 1'b1; flush = 1'b0; start = 1'b0;
      checks++; if (busy !== 1'b0 || done !== 1'b0 || div_zero !== 1'b0 || result !== 64'd0) begin
         errors++; $display("FAIL mid_reset got busy=%b done=%b dz=%b result=%h want all 0", busy, done, div_zero, result);
      end
      src_a = $urandom; src_b = 32'($urandom_range(1, 50));
      model_op(3'd2, src_a, src_b, 64'd0, exp, edz);
      issue(3'd2, src_a, src_b, 64'd0, res, dz, lat, bok);
      checks++; if (res !== exp || lat !== 35) begin errors++; $display("FAIL after_reset got %h lat %0d want %h lat 35", res, lat, exp); end
   endtask

   initial begin
      rst = 1'b0; flush = 1'b0; start = 1'b0; op = 3'd0;
      src_a = '0; src_b = '0; acc_i = '0;
      test_reset();
      test_directed();
      test_hold();
      test_random();
      test_back_to_back();
      test_flush();
      test_flush_start();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
